frame_aligner: RTL

//  Demap-path framer directly upstream of crc_calc (MAP_MODE=0). Hunts the FAS word in a raw byte stream
//  and confirms alignment over consecutive frames. Emits each byte tagged with row/column count and a FAS

---
 rtl/frame_aligner_pkg.sv | 38 +++
 rtl/frame_aligner_if.sv | 26 ++
 rtl/frame_aligner_fas_window.sv | 30 +++
 rtl/frame_aligner.sv | 137 +++++++++++++
 4 files changed

// File: rtl/frame_aligner_pkg.sv
// Shared frame geometry, FAS pattern and aligner state encoding for the demap path.
// crc_calc and the mapper import the same constants.
package frame_aligner_pkg;

    localparam int unsigned ROW_LEN      = 1041;
    localparam int unsigned NUM_ROWS     = 4;
    localparam int unsigned OH_LAST_COL  = 15;
    localparam int unsigned PL_FIRST_COL = 16;
    localparam int unsigned PL_LAST_COL  = 1039;
    localparam int unsigned CRC_COL      = 1040;
    localparam int unsigned CRC_ROW      = 3;
    localparam int unsigned ROW_W        = 2;
    localparam int unsigned COL_W        = 11;

    localparam logic [31:0] FAS_WORD = 32'hF6F62828;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } align_state_t;

    // Advance a (row,col) tag by one byte, wrapping col then row.
    function automatic logic [ROW_W+COL_W-1:0] next_pos(input logic [ROW_W-1:0] row,
                                                        input logic [COL_W-1:0] col);
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        if (col == COL_W'(ROW_LEN - 1)) begin
            c = '0;
            r = (row == ROW_W'(NUM_ROWS - 1)) ? '0 : row + ROW_W'(1);
        end else begin
            c = col + COL_W'(1);
            r = row;
        end
        return {r, c};
    endfunction

endpackage

// File: rtl/frame_aligner_if.sv
// Byte-stream bundle between the line side and the aligner, plus the tagged aligned output.
interface frame_aligner_if;

    logic [7:0]  i_data;
    logic        i_data_valid;
    logic [7:0]  o_frame_data;
    logic        o_frame_data_valid;
    logic        o_frame_data_fas;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_lock;
    logic        o_lof;

    modport master (
        output i_data, i_data_valid,
        input  o_frame_data, o_frame_data_valid, o_frame_data_fas,
        input  o_row_cnt, o_col_cnt, o_lock, o_lof
    );

    modport slave (
        input  i_data, i_data_valid,
        output o_frame_data, o_frame_data_valid, o_frame_data_fas,
        output o_row_cnt, o_col_cnt, o_lock, o_lof
    );

endinterface

// File: rtl/frame_aligner_fas_window.sv
// Four-byte FAS window: three stored bytes plus the byte being shifted in this cycle.
// The oldest of those four is the candidate output byte; match compares the whole window.
module fas_window
    import frame_aligner_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_shift,
    input  logic [7:0] i_data,
    output logic [7:0] win_oldest,
    output logic       match
);

    logic [23:0] hist_q;
    logic [31:0] win;

    assign win = {hist_q, i_data};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hist_q <= '0;
        end else if (i_shift) begin
            hist_q <= win[23:0];
        end
    end

    assign win_oldest = win[31:24];
    assign match      = i_shift && (win == FAS_WORD);

endmodule

// File: rtl/frame_aligner.sv
// FAS hunt / confirm / flywheel framer; tags each aligned byte with row, col and FAS flag.
//   state   | meaning
//   HUNT    | searching every valid byte for FAS, no output
//   PRESYNC | FAS found, confirming at each (0,0) check point
//   SYNC    | locked, flywheel tolerates LOSS_FRAMES-1 bad checks
module frame_aligner
    import frame_aligner_pkg::*;
#(
    parameter int unsigned SYNC_FRAMES = 2,
    parameter int unsigned LOSS_FRAMES = 3
)
(
    input  logic           i_clk,
    input  logic           i_rst,
    frame_aligner_if.slave bus
);

    localparam logic [2:0] SYNC_CNT = 3'(SYNC_FRAMES);
    localparam logic [2:0] LOSS_CNT = 3'(LOSS_FRAMES);

    align_state_t     state_q, state_d;
    logic [2:0]       good_q, good_d;
    logic [2:0]       bad_q, bad_d;
    logic [ROW_W-1:0] row_q, row_d, out_row;
    logic [COL_W-1:0] col_q, col_d, out_col;
    logic             out_en, out_fas, lof_d;
    logic             at_check, match;
    logic [7:0]       win_oldest;

    fas_window u_fas_window (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_shift    (bus.i_data_valid),
        .i_data     (bus.i_data),
        .win_oldest (win_oldest),
        .match      (match)
    );

    assign at_check = (row_q == '0) && (col_q == '0);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        row_d   = row_q;
        col_d   = col_q;
        out_en  = 1'b0;
        out_fas = 1'b0;
        out_row = row_q;
        out_col = col_q;
        lof_d   = 1'b0;
        if (bus.i_data_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (match) begin
                        out_en         = 1'b1;
                        out_fas        = 1'b1;
                        out_row        = '0;
                        out_col        = '0;
                        {row_d, col_d} = next_pos('0, '0);
                        good_d         = 3'd1;
                        bad_d          = '0;
                        state_d        = (SYNC_CNT <= 3'd1) ? SYNC : PRESYNC;
                    end
                end
                PRESYNC: begin
                    out_en         = 1'b1;
                    out_fas        = at_check;
                    {row_d, col_d} = next_pos(row_q, col_q);
                    if (at_check) begin
                        if (match) begin
                            good_d = good_q + 3'd1;
                            if (good_d == SYNC_CNT) state_d = SYNC;
                        end else begin
                            out_en  = 1'b0;
                            good_d  = '0;
                            state_d = HUNT;
                        end
                    end
                end
                SYNC: begin
                    out_en         = 1'b1;
                    out_fas        = at_check;
                    {row_d, col_d} = next_pos(row_q, col_q);
                    if (at_check) begin
                        if (match) begin
                            bad_d = '0;
                        end else begin
                            bad_d = bad_q + 3'd1;
                            // Loss of frame: the failing check byte is dropped.
                            if (bad_d == LOSS_CNT) begin
                                out_en  = 1'b0;
                                lof_d   = 1'b1;
                                good_d  = '0;
                                state_d = HUNT;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q                <= HUNT;
            good_q                 <= '0;
            bad_q                  <= '0;
            row_q                  <= '0;
            col_q                  <= '0;
            bus.o_frame_data       <= '0;
            bus.o_frame_data_valid <= 1'b0;
            bus.o_frame_data_fas   <= 1'b0;
            bus.o_row_cnt          <= '0;
            bus.o_col_cnt          <= '0;
            bus.o_lock             <= 1'b0;
            bus.o_lof              <= 1'b0;
        end else begin
            state_q                <= state_d;
            good_q                 <= good_d;
            bad_q                  <= bad_d;
            row_q                  <= row_d;
            col_q                  <= col_d;
            bus.o_frame_data_valid <= out_en;
            bus.o_lof              <= lof_d;
            bus.o_lock             <= (state_d == SYNC);
            if (out_en) begin
                bus.o_frame_data     <= win_oldest;
                bus.o_frame_data_fas <= out_fas;
                bus.o_row_cnt        <= out_row;
                bus.o_col_cnt        <= out_col;
            end
        end
    end

endmodule
